fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences the instruction memory: drives the 8-bit PC, captures each 24-bit instruction returned by the combinational memory read, and presents {pc, instr} to decode through a valid/ready handshake. A 2-entry fetch queue absorbs decode back-pressure, so fetch never stalls the memory read path. Branch/jump redirects flush the queue and reload the PC. The block sits between the instruction memory and the decode stage.

Parameters:
PC_W, 8, PC and memory address width
INSTR_W, 24, instruction width
RESET_PC, 0, PC value loaded on reset
QDEPTH, 2, fetch queue depth; fixed at 2, other values unsupported

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 stops new fetches
imem_pc  out  PC_W  address to instruction memory
imem_instr  in  INSTR_W  instruction read combinationally at imem_pc
redirect_valid  in  1  one-cycle pulse: flush and load PC
redirect_pc  in  PC_W  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  PC_W  PC of head instruction
out_instr  out  INSTR_W  head instruction
halted  out  1  fetch stopped on HALT (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, queue empty (count=0, rd/wr ptr=0), state=IDLE. Outputs: imem_pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, halted=0.
- imem_pc = pc_q at all times (combinational). imem_instr is sampled in the same cycle.
- States:
  - IDLE: no push. Go to FETCH when en=1.
  - FETCH: push when en=1 and (count<2 or pop this cycle). On push: queue gets {pc_q, imem_instr}; pc_q <= pc_q+1, modulo 2^PC_W (wraps 255->0). en=0 -> IDLE. The queue keeps draining while in IDLE.
  - HALT: exists only with the optional feature.
- Pop = out_valid & out_ready. out_valid = (count!=0). out_pc/out_instr show the head entry and stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop at count=2: both occur, count stays 2. At count=0, push then pop next cycle: the queue does not bypass. Latency from PC drive to out_valid is 1 cycle.
- Redirect has priority over everything that cycle: count<=0, pc_q<=redirect_pc, and no push that cycle. A pop in the same cycle is ignored; decode must treat that head as flushed. The state goes to FETCH if en=1, otherwise IDLE. A HALT state is cleared by redirect. Fetch from redirect_pc begins the next cycle, and its instruction appears on out_* 2 cycles after the redirect cycle.
- out_ready asserted with out_valid=0: no effect.
- Reset asserted mid-operation: the queue is lost and all outputs return to reset values immediately.

Optional Feature:
FETCH_HALT_DETECT_EN
- Defined: a pushed instruction with imem_instr[23:20]==4'hF is enqueued normally. The state then goes to HALT: no further pushes, pc_q holds at (halt PC + 1), halted=1. The queue drains. Only a redirect or reset leaves HALT; halted deasserts the cycle after the redirect.
- Undefined: opcode 4'hF gets no special treatment, the HALT state does not exist, and halted is constant 0.

Test Plan:
- Reset then en=1, out_ready=1, memory holding instr=pc*0x010101 -> out_pc 0,1,2,... on consecutive cycles, out_instr 0x000000, 0x010101, 0x020202, one per cycle after the first-cycle latency.
- out_ready=0 for 5 cycles from start -> exactly 2 entries queued (pc 0,1), imem_pc holds 2, out_* stable at pc 0. With out_ready=1 afterwards -> pc 0,1,2,3 in order, no gap or duplicate.
- Redirect to 0x40 while count=2 and out_ready=1 -> queue flushed, next outputs pc 0x40, 0x41, no stale pc delivered.
- Start at redirect_pc=0xFE, free-running -> out_pc 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Assert rst_n=0 asynchronously mid-stream with count=2 -> out_valid=0 and imem_pc=0 before the next clock edge. After release, fetch restarts at pc 0.
- With FETCH_HALT_DETECT_EN, instr at pc 3 = 0xF00000 -> pc 0..3 delivered, halted=1, no pc 4 until redirect to 0x10, then pc 0x10 delivered and halted=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the instruction-memory PC, captures the combinational
// read and hands {pc, instr} to decode through a 2-entry fetch queue.
// Optional build macro: FETCH_HALT_DETECT_EN (stop fetching after an opcode 4'hF
// instruction until a redirect arrives).
module fetch_sequencer #(
  parameter int unsigned        PC_W     = 8,
  parameter int unsigned        INSTR_W  = 24,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter int unsigned        QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               halted
);

  localparam int unsigned      CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(QDEPTH);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH} state_e;
`endif

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]    ent_pc_q    [2];
  logic [INSTR_W-1:0] ent_instr_q [2];
  logic               push;
  logic               pop;

  assign imem_pc   = pc_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_pc    = out_valid ? ent_pc_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? ent_instr_q[rd_ptr_q] : '0;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // Next-state logic: redirect flushes and reloads, otherwise fetch/drain the queue
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = 1'b0;
    if (redirect_valid) begin
      // A pop in this cycle is discarded along with the rest of the queue.
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = redirect_pc;
      state_d  = en ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!en) begin
            state_d = S_IDLE;
          end else if ((count_q < FULL) || pop) begin
            push = 1'b1;
            pc_d = pc_q + PC_W'(1);
`ifdef FETCH_HALT_DETECT_EN
            if (imem_instr[INSTR_W-1 -: 4] == 4'hF) state_d = S_HALT;
`endif
          end
        end
`ifdef FETCH_HALT_DETECT_EN
        S_HALT: begin
          state_d = S_HALT;
        end
`endif
        default: state_d = S_IDLE;
      endcase
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state: FSM, PC, queue occupancy and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage: written on push only; contents are masked by count on output
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]    <= pc_q;
      ent_instr_q[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected {pc, instr}
// entries; a negedge monitor pops and compares each accepted output.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_ready = 1'b0;
  logic [7:0]  imem_pc;
  logic [23:0] imem_instr;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic [23:0] out_instr;
  logic        halted;
  logic        halt_mem = 1'b0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [23:0] instr;
  } ent_t;

  ent_t expq[$];
  int   errors = 0;
  int   checks = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Memory image: word = pc * 0x010101; optional HALT opcode planted at pc 3.
  function automatic logic [23:0] mem_word(input logic [7:0] pc, input logic hm);
    logic [23:0] w;
    w = {pc, pc, pc};
    if (hm && pc == 8'd3) begin
      w = 24'hF00000;
    end
`ifdef FETCH_HALT_DETECT_EN
    else if (w[23:20] == 4'hF) begin
      w[23] = 1'b0;
    end
`endif
    return w;
  endfunction

  assign imem_instr = mem_word(imem_pc, halt_mem);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [7:0] pc);
    expq.push_back({pc, mem_word(pc, halt_mem)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    en             = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    expq.delete();
    step(2);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (expq.size() == 0) break;
      step(1);
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending entries expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  // Monitor: every accepted head (not flushed by a same-cycle redirect) is checked
  always @(negedge clk) begin
    ent_t e;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc %0h instr %0h expected nothing", out_pc, out_instr);
      end else begin
        e = expq.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++;
          $display("FAIL out_entry: got pc %0h instr %0h expected pc %0h instr %0h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imem_pc",   imem_pc,   0);
    chk("rst_out_pc",    out_pc,    0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_halted",    halted,    0);

    // Free-running stream from reset
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int p = 0; p < 8; p++) expect_pc(8'(p));
    wait_drain("stream");
    chk("run_halted", halted, 0);
    apply_reset();

    // Back-pressure: queue fills with pc 0,1 and holds
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b0;
    for (int p = 0; p < 6; p++) expect_pc(8'(p));
    step(5);
    chk("stall_valid",   out_valid, 1);
    chk("stall_pc",      out_pc,    0);
    chk("stall_instr",   out_instr, 0);
    chk("stall_imem_pc", imem_pc,   2);
    step(1);
    chk("stall_pc_hold",   out_pc,  0);
    chk("stall_imem_hold", imem_pc, 2);
    out_ready = 1'b1;
    wait_drain("stall");
    apply_reset();

    // Redirect with a full queue and decode ready
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b0;
    step(5);
    redirect_valid = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1;
    for (int p = 'h40; p < 'h44; p++) expect_pc(8'(p));
    step(1);
    redirect_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    wait_drain("redirect");
    apply_reset();

    // PC wrap from 0xFE
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    expect_pc(8'hFE); expect_pc(8'hFF); expect_pc(8'h00); expect_pc(8'h01); expect_pc(8'h02);
    step(1);
    redirect_valid = 1'b0;
    wait_drain("wrap");
    apply_reset();

    // Asynchronous reset mid-stream with a full queue
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b0;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",   out_valid, 0);
    chk("arst_imem_pc", imem_pc,   0);
    chk("arst_out_pc",  out_pc,    0);
    chk("arst_instr",   out_instr, 0);
    step(1);
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int p = 0; p < 4; p++) expect_pc(8'(p));
    wait_drain("restart");
    apply_reset();

`ifdef FETCH_HALT_DETECT_EN
    // HALT opcode at pc 3 stops fetch until redirect
    halt_mem = 1'b1;
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int p = 0; p < 4; p++) expect_pc(8'(p));
    wait_drain("halt");
    step(3);
    chk("halt_flag",    halted,    1);
    chk("halt_valid",   out_valid, 0);
    chk("halt_imem_pc", imem_pc,   4);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    for (int p = 'h10; p < 'h13; p++) expect_pc(8'(p));
    step(1);
    redirect_valid = 1'b0;
    chk("halt_clear", halted, 0);
    wait_drain("halt_resume");
    apply_reset();
    halt_mem = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
